// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared display definitions: command codes, ASCII constants,
//               controller state encoding and BCD digit helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  // Command codes on the display command stream
  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_SCROLL = 4'h1;
  localparam logic [3:0] CMD_NUMBER = 4'h2;

  // ASCII characters produced by the number formatter
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // Number of BCD digits delivered by the converter
  localparam int BCD_DIGITS = 10;

  // Number formatter sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } fmt_state_t;

  // Select one BCD digit by index; out-of-range indices read as zero
  function automatic logic [3:0] bcd_digit(
    input logic [4*BCD_DIGITS-1:0] bcd,
    input logic [3:0]              idx
  );
    logic [3:0] d;
    d = 4'h0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (idx == 4'(i)) begin
        d = bcd[4*i +: 4];
      end
    end
    return d;
  endfunction

  // ASCII code of a single decimal digit
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_msd_find.sv
`default_nettype none
// ============================================================================
// Module      : bcd_msd_find
// Description : Index of the most significant nonzero digit of a 10-digit
//               BCD word; reports 0 when every digit is zero, so a zero
//               value still yields one digit to print.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_msd_find
  import disp_pkg::*;
(
  input  logic [4*BCD_DIGITS-1:0] bcd,
  output logic [3:0]              msd
);

  // Scan upward so the last nonzero digit found is the most significant one
  always_comb begin
    msd = 4'h0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'h0) begin
        msd = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/num_fmt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : num_fmt_ctrl
// Description : Command sequencer for the shared binary-to-BCD converter.
//               Accepts NOP/SCROLL/NUMBER commands, runs a conversion for
//               NUMBER and streams the signed decimal result as ASCII with
//               leading-zero suppression down to MIN_DIGITS digits.
// Revision    : 1.0 - initial release
// ============================================================================
module num_fmt_ctrl
  import disp_pkg::*;
#(
  parameter int MIN_DIGITS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // command stream
  input  logic                    cmd_valid,
  input  logic [3:0]              cmd,
  input  logic [31:0]             cmd_data,
  output logic                    cmd_ready,
  // converter side
  output logic                    conv_start,
  output logic [31:0]             conv_bin,
  input  logic [4*BCD_DIGITS-1:0] conv_bcd,
  input  logic                    conv_sign,
  input  logic                    conv_ready,
  // character sink
  output logic                    char_valid,
  output logic [7:0]              char,
  input  logic                    char_ready,
  // side-band pulses
  output logic                    scroll,
  output logic                    cmd_err
);

  // Lowest digit index that is always printed (zero padding floor)
  localparam logic [3:0] MIN_IDX = 4'(MIN_DIGITS - 1);

  fmt_state_t              state;
  logic [4*BCD_DIGITS-1:0] bcd_q;      // latched conversion result
  logic [3:0]              digit_idx;  // digit currently presented / next
  logic                    sign_pend;  // '-' is the character on the output

  logic [3:0] msd;
  logic [3:0] first_idx;
  logic       cmd_accept;
  logic       char_take;

  bcd_msd_find u_msd_find (
    .bcd (conv_bcd),
    .msd (msd)
  );

  // Command handshake is open only while idle; it reads 1 during reset
  assign cmd_ready  = (state == ST_IDLE);
  assign cmd_accept = cmd_valid & cmd_ready;
  assign char_take  = char_valid & char_ready;

  // Start digit: the most significant nonzero digit, but never below the padding floor
  assign first_idx = (msd > MIN_IDX) ? msd : MIN_IDX;

  // Sequencer with registered converter, character and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      conv_start <= 1'b0;
      conv_bin   <= 32'h0;
      char_valid <= 1'b0;
      char       <= 8'h00;
      scroll     <= 1'b0;
      cmd_err    <= 1'b0;
      bcd_q      <= '0;
      digit_idx  <= 4'h0;
      sign_pend  <= 1'b0;
    end else begin
      scroll     <= 1'b0;
      cmd_err    <= 1'b0;
      conv_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_accept) begin
            case (cmd)
              CMD_NOP: begin
              end
              CMD_SCROLL: begin
                scroll <= 1'b1;
              end
              CMD_NUMBER: begin
                conv_bin <= cmd_data;
                state    <= ST_ARM;
              end
              default: begin
                cmd_err <= 1'b1;
              end
            endcase
          end
        end

        // Converter may still be busy after a reset of this block only
        ST_ARM: begin
          if (conv_ready) begin
            conv_start <= 1'b1;
            state      <= ST_START;
          end
        end

        // conv_start is high during this cycle; converter ready is gated off
        ST_START: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (conv_ready) begin
            bcd_q      <= conv_bcd;
            sign_pend  <= conv_sign;
            digit_idx  <= first_idx;
            char_valid <= 1'b1;
            char       <= conv_sign ? CH_MINUS
                                    : digit_char(bcd_digit(conv_bcd, first_idx));
            state      <= ST_EMIT;
          end
        end

        // Advance only on a completed handshake so the character stays stable
        ST_EMIT: begin
          if (char_take) begin
            if (sign_pend) begin
              sign_pend <= 1'b0;
              char      <= digit_char(bcd_digit(bcd_q, digit_idx));
            end else if (digit_idx == 4'h0) begin
              char_valid <= 1'b0;
              char       <= 8'h00;
              state      <= ST_IDLE;
            end else begin
              digit_idx <= digit_idx - 4'd1;
              char      <= digit_char(bcd_digit(bcd_q, digit_idx - 4'd1));
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_num_fmt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_num_fmt_ctrl
// Description : Scoreboard bench for num_fmt_ctrl with a behavioural
//               32-step converter model; two instances (MIN_DIGITS 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_num_fmt_ctrl;
  import disp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid  [2];
  logic [3:0]  cmd        [2];
  logic [31:0] cmd_data   [2];
  logic        cmd_ready  [2];
  logic        conv_start [2];
  logic [31:0] conv_bin   [2];
  logic [39:0] conv_bcd   [2] = '{40'h0, 40'h0};
  logic        conv_sign  [2] = '{1'b0, 1'b0};
  logic        conv_ready [2];
  logic        char_valid [2];
  logic [7:0]  chr        [2];
  logic        char_ready [2];
  logic        scroll     [2];
  logic        cmd_err    [2];

  num_fmt_ctrl #(.MIN_DIGITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd(cmd[0]), .cmd_data(cmd_data[0]), .cmd_ready(cmd_ready[0]),
    .conv_start(conv_start[0]), .conv_bin(conv_bin[0]), .conv_bcd(conv_bcd[0]),
    .conv_sign(conv_sign[0]), .conv_ready(conv_ready[0]),
    .char_valid(char_valid[0]), .char(chr[0]), .char_ready(char_ready[0]),
    .scroll(scroll[0]), .cmd_err(cmd_err[0])
  );

  num_fmt_ctrl #(.MIN_DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd(cmd[1]), .cmd_data(cmd_data[1]), .cmd_ready(cmd_ready[1]),
    .conv_start(conv_start[1]), .conv_bin(conv_bin[1]), .conv_bcd(conv_bcd[1]),
    .conv_sign(conv_sign[1]), .conv_ready(conv_ready[1]),
    .char_valid(char_valid[1]), .char(chr[1]), .char_ready(char_ready[1]),
    .scroll(scroll[1]), .cmd_err(cmd_err[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- converter model (no reset, 32 busy cycles) ----------
  logic busy [2] = '{1'b0, 1'b0};
  int   cnt  [2] = '{0, 0};

  function automatic logic [40:0] to_bcd(input logic [31:0] b);
    longint     v;
    logic       s;
    logic [39:0] r;
    v = longint'(signed'(b));
    s = (v < 0);
    if (v < 0) v = -v;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {s, r};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (conv_start[i]) begin
        busy[i] <= 1'b1;
        cnt[i]  <= 31;
        {conv_sign[i], conv_bcd[i]} <= to_bcd(conv_bin[i]);
      end else if (busy[i]) begin
        if (cnt[i] == 0) busy[i] <= 1'b0;
        else             cnt[i]  <= cnt[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) conv_ready[i] = !busy[i] && !conv_start[i];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic push(input int i, input string s);
    for (int j = 0; j < s.len(); j++) begin
      if (i == 0) q0.push_back(s[j]);
      else        q1.push_back(s[j]);
    end
  endtask

  int         nchars   [2] = '{0, 0};
  int         scroll_n [2] = '{0, 0};
  int         err_n    [2] = '{0, 0};
  int         start_n  [2] = '{0, 0};
  int         scroll_cyc = 0;
  int         err_cyc    = 0;
  int         start_cyc  = 0;
  logic       held_v [2] = '{1'b0, 1'b0};
  logic [7:0] held_c [2] = '{8'h0, 8'h0};

  // Monitor: pops and compares every accepted character, checks hold stability
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (held_v[i]) check("hold_stable", {char_valid[i], chr[i]}, {1'b1, held_c[i]});
        if (char_valid[i] && char_ready[i]) begin
          nchars[i]++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char inst=%0d actual=%h required=none", i, chr[i]);
          end else begin
            check("char", chr[i], (i == 0) ? q0.pop_front() : q1.pop_front());
          end
        end
        held_v[i] = char_valid[i] && !char_ready[i];
        held_c[i] = chr[i];
        if (scroll[i])     begin scroll_n[i]++; if (i == 0) scroll_cyc = cyc; end
        if (cmd_err[i])    begin err_n[i]++;    if (i == 0) err_cyc    = cyc; end
        if (conv_start[i]) begin start_n[i]++;  if (i == 0) start_cyc  = cyc; end
      end else begin
        held_v[i] = 1'b0;
      end
    end
  end

  // ---------------- sink ready driver ----------------
  int       rdy_mode = 0;
  logic [3:0] rdy_pat = 4'b1001;
  int       rdy_k    = 0;

  initial begin
    char_ready[0] = 1'b1;
    char_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 0) begin
        char_ready[0] = rdy_pat[rdy_k];
        rdy_k = (rdy_k + 1) % 4;
      end else begin
        char_ready[0] = 1'b1;
        rdy_k = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int i, input logic [3:0] c, input logic [31:0] d, output int c_cyc);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid[i] = 1'b1;
    cmd[i]       = c;
    cmd_data[i]  = d;
    while (!cmd_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout inst=%0d actual=0 required=1", i);
    end
    c_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, output int at_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout inst=%0d actual=0 required=1", i);
    end
    at_cyc = cyc;
  endtask

  int c, d, t, cs, cn, ce, s0, e0, n0, sn;

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd[i]       = 4'h0;
      cmd_data[i]  = 32'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_cmd_ready",  cmd_ready[0], 1);
    check("rst_conv_start", conv_start[0], 0);
    check("rst_conv_bin",   conv_bin[0], 0);
    check("rst_char_valid", char_valid[0], 0);
    check("rst_char",       chr[0], 0);
    check("rst_pulses",     {scroll[0], cmd_err[0]}, 0);
    rst_n = 1'b1;

    // 12345 with exact latency
    push(0, "12345");
    issue(0, CMD_NUMBER, 32'd12345, c);
    t = 0;
    while (!char_valid[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("first_char_cycle", cyc, c + 36);
    wait_idle(0, t);
    check("cmd_ready_back_cycle", t, c + 41);

    // sign and zero
    push(0, "-7");
    issue(0, CMD_NUMBER, -32'sd7, c);
    wait_idle(0, t);
    push(0, "0");
    issue(0, CMD_NUMBER, 32'd0, c);
    wait_idle(0, t);

    // zero padding to three digits
    push(1, "000");
    issue(1, CMD_NUMBER, 32'd0, c);
    wait_idle(1, t);
    push(1, "007");
    issue(1, CMD_NUMBER, 32'd7, c);
    wait_idle(1, t);
    push(1, "-12345");
    issue(1, CMD_NUMBER, -32'sd12345, c);
    wait_idle(1, t);

    // range extremes
    push(0, "-2147483648");
    issue(0, CMD_NUMBER, 32'h8000_0000, c);
    wait_idle(0, t);
    push(0, "2147483647");
    issue(0, CMD_NUMBER, 32'h7FFF_FFFF, c);
    wait_idle(0, t);

    // back-pressure 1-0-0-1
    rdy_mode = 1;
    push(0, "905");
    n0 = nchars[0];
    issue(0, CMD_NUMBER, 32'd905, c);
    wait_idle(0, t);
    rdy_mode = 0;
    check("bp_char_count", nchars[0] - n0, 3);

    // SCROLL, NOP, unknown back-to-back
    s0 = scroll_n[0];
    e0 = err_n[0];
    n0 = nchars[0];
    issue(0, CMD_SCROLL, 32'h0, cs);
    issue(0, CMD_NOP,    32'h0, cn);
    issue(0, 4'hF,       32'h0, ce);
    repeat (3) @(negedge clk);
    check("back_to_back_accept", {cn - cs, ce - cs}, {32'd1, 32'd2});
    check("scroll_pulse_count", scroll_n[0] - s0, 1);
    check("scroll_pulse_cycle", scroll_cyc, cs + 1);
    check("err_pulse_count", err_n[0] - e0, 1);
    check("err_pulse_cycle", err_cyc, ce + 1);
    check("no_chars_on_cmds", nchars[0] - n0, 0);
    check("cmd_ready_held", cmd_ready[0], 1);

    // reset during conversion, then a new number while converter still busy
    issue(0, CMD_NUMBER, 32'd99999, c);
    t = 0;
    while (cyc < c + 20 && t < 100) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    #1;
    check("abort_char_valid", char_valid[0], 0);
    check("abort_cmd_ready", cmd_ready[0], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sn = start_n[0];
    push(0, "42");
    issue(0, CMD_NUMBER, 32'd42, d);
    wait_idle(0, t);
    check("arm_start_count", start_n[0] - sn, 1);
    check("arm_start_cycle", start_cyc, c + 36);

    repeat (3) @(negedge clk);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/num_fmt_ctrl.md
# num_fmt_ctrl

Command-driven sequencer for the shared `bin_to_bcd` converter. It accepts NOP/SCROLL/NUMBER commands from the display command stream and starts the converter for NUMBER commands. It then waits for the conversion to finish and streams the result as ASCII characters, with sign and leading-zero suppression, to the character sink. It sits between the command source and the text/scroll display logic; the converter is instantiated beside it at top level.

## Interface
- `MIN_DIGITS`, default 1: minimum number of digit characters emitted, zero-padded on the left; legal 1..10.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd` in 4: command code: 4'h0 NOP, 4'h1 SCROLL, 4'h2 NUMBER.
- `cmd_data` in 32: signed operand for NUMBER; ignored otherwise.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `conv_start` out 1: converter start pulse; registered.
- `conv_bin` out 32: converter operand; registered.
- `conv_bcd` in 40: converter result, 10 BCD digits, digit 9 in [39:36].
- `conv_sign` in 1: converter sign; 1 means negative.
- `conv_ready` in 1: converter idle/result valid.
- `char_valid` out 1: character present.
- `char` out 8: ASCII character.
- `char_ready` in 1: sink accepts the character.
- `scroll` out 1: one-cycle scroll pulse.
- `cmd_err` out 1: one-cycle pulse on an unknown command code.

## Operation
- States: IDLE, ARM, START, WAIT, EMIT.
- IDLE
  - `cmd_ready`=1, and only in IDLE.
  - On accept, NOP: stay in IDLE, no effect.
  - On accept, SCROLL: `scroll`=1 the next cycle, stay in IDLE.
  - On accept, unknown code: `cmd_err`=1 the next cycle, treat as NOP.
  - On accept, NUMBER: latch `cmd_data` into `conv_bin`, go to ARM.
- ARM: when `conv_ready`=1 is sampled, register `conv_start`<=1 and go to START. Otherwise hold in ARM. This covers a converter still busy after a mid-conversion reset of this block, since the converter itself has no reset.
- START: `conv_start`=1 for exactly this one cycle, then go to WAIT.
- `conv_start` must never depend combinationally on `conv_ready`; the converter's ready is gated by start, so such a path forms a loop.
- WAIT: on `conv_ready`=1, latch `conv_bcd`/`conv_sign`, compute the emit list, go to EMIT.
- Emit list:
  - `'-'` (8'h2D) first if sign=1.
  - Then digits from index max(msd, MIN_DIGITS-1) down to 0, each as 8'h30+digit.
  - msd is the highest nonzero digit index, or 0 if all digits are zero, so "0" is always emitted for zero.
- EMIT: one character per `char_valid & char_ready`. When the last character is accepted, return to IDLE.
- Valid/ready rule: `char` and `char_valid` stay stable while `char_valid & !char_ready`.
- Range: -2147483648 converts to magnitude 2147483648; 11 characters with sign.
- Reset values:
  - state IDLE.
  - `cmd_ready`=1 combinational from IDLE, so it reads 1 in reset.
  - `conv_start`=0, `conv_bin`=0, `char_valid`=0, `char`=0, `scroll`=0, `cmd_err`=0.
- Reset asserted mid-sequence aborts the sequence; no partial character stream resumes.

## Timing
- Cycle C: NUMBER handshake.
- Cycle C+1: ARM samples `conv_ready`.
- Cycle C+2: `conv_start`=1; `conv_ready` reads 0 and WAIT ignores it.
- Cycles C+3..C+34: converter performs its 32 shift steps.
- Cycle C+35: `conv_ready`=1; WAIT latches the result.
- Cycle C+36: first `char_valid`.
- With `char_ready` held 1: N characters occupy C+36..C+35+N, and `cmd_ready`=1 from C+36+N.
- SCROLL/NOP/unknown: next command can be accepted in C+1; `scroll` / `cmd_err` appear in C+1.
- Worst-case command-to-first-character latency is 36 cycles, plus any ARM stall.

## Structure
- Shared package `disp_pkg`:
  - command codes CMD_NOP=4'h0, CMD_SCROLL=4'h1, CMD_NUMBER=4'h2;
  - ASCII constants CH_MINUS=8'h2D, CH_ZERO=8'h30;
  - BCD_DIGITS=10.
- Sub-module `bcd_msd_find`: combinational, 40-bit BCD in, 4-bit index of the most significant nonzero digit out (0 if all zero).
- The controller uses a 4-bit down-counter for the digit index plus a sign-pending flag.

## Test plan
- NUMBER 12345, `char_ready`=1 → chars "1","2","3","4","5"; first at C+36; `cmd_ready` back at C+41.
- NUMBER -7 then NUMBER 0 → "-","7", then "0"; with MIN_DIGITS=3, NUMBER 0 → "0","0","0".
- NUMBER -2147483648 → "-2147483648" (11 chars); NUMBER 2147483647 → "2147483647".
- NUMBER 905 with `char_ready` toggling 1-0-0-1 → each char held stable until accepted; no drops or duplicates.
- SCROLL, NOP, 4'hF back-to-back → `scroll` pulse 1 cycle, no chars, `cmd_err` pulse 1 cycle; `cmd_ready` stays 1.
- Reset asserted at C+20 of a NUMBER (converter still busy) → `char_valid`=0 immediately. Then NUMBER 42 → ARM holds until `conv_ready`, `conv_start` pulses once, output "42".
